bullet_pool: RTL and testbench

Multi-shot projectile manager for one player ship. Holds NUM_BULLETS independent bullet slots, launches one per fire-key press from the ship centre in the ship's current facing, and advances all live bullets each frame. Retires bullets at the screen edge or on an external hit. Sits between the keyboard/ship logic and the colour mapper and collision logic.

---
 rtl/bullet_pool.sv | 158 +++++++++++++++
 tb/tb_bullet_pool.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot projectile manager for one ship, stepped on frame_clk.
// Optional build macro AUTO_FIRE_EN: holding FIRE_KEY repeats launches every COOLDOWN+1 frames.
module bullet_pool #(
    parameter int          NUM_BULLETS = 4,
    parameter logic [7:0]  FIRE_KEY    = 8'd88,
    parameter logic [9:0]  STEP        = 10'd12,
    parameter logic [3:0]  COOLDOWN    = 4'd6,
    parameter logic [9:0]  SIZE        = 10'd4,
    parameter logic [9:0]  X_MIN       = 10'd1,
    parameter logic [9:0]  X_MAX       = 10'd639,
    parameter logic [9:0]  Y_MIN       = 10'd1,
    parameter logic [9:0]  Y_MAX       = 10'd479
) (
    input  logic                        Reset,
    input  logic                        frame_clk,
    input  logic [1:0]                  direction,
    input  logic [7:0]                  keycode,
    input  logic [9:0]                  ShipX,
    input  logic [9:0]                  ShipY,
    input  logic [9:0]                  ShipS,
    input  logic [NUM_BULLETS-1:0]      hit,
    output logic [10*NUM_BULLETS-1:0]   BulletX,
    output logic [10*NUM_BULLETS-1:0]   BulletY,
    output logic [9:0]                  BulletS,
    output logic [NUM_BULLETS-1:0]      bullet_on,
    output logic                        fire_event,
    output logic [3:0]                  active_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_e;

    slot_e      state_q [NUM_BULLETS];
    slot_e      state_d [NUM_BULLETS];
    logic [9:0] x_q     [NUM_BULLETS];
    logic [9:0] x_d     [NUM_BULLETS];
    logic [9:0] y_q     [NUM_BULLETS];
    logic [9:0] y_d     [NUM_BULLETS];
    logic [1:0] dir_q   [NUM_BULLETS];
    logic [1:0] dir_d   [NUM_BULLETS];

    logic [3:0] cd_q, cd_d;
    logic       key_prev_q;
    logic       fire_q, fire_d;
    logic [3:0] cnt_q, cnt_d;

    logic [9:0] cx, cy;
    logic       key_dn, trig, launch, free_found, at_edge;
    logic [2:0] free_idx;

    assign cx     = ShipX + ShipS;
    assign cy     = ShipY + ShipS;
    assign key_dn = (keycode == FIRE_KEY);

`ifdef AUTO_FIRE_EN
    assign trig = key_dn;
`else
    assign trig = key_dn & ~key_prev_q;
`endif

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (state_q[i] == IDLE && !free_found) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    assign launch = trig & (cd_q == 4'd0) & free_found;

    // Idle and retiring slots both follow the ship centre.
    always_comb begin
        at_edge = 1'b0;
        cnt_d   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            state_d[i] = state_q[i];
            dir_d[i]   = dir_q[i];
            x_d[i]     = cx;
            y_d[i]     = cy;
            at_edge = (({1'b0, y_q[i]} + {1'b0, SIZE}) >= {1'b0, Y_MAX})
                    | (y_q[i] <= Y_MIN + SIZE)
                    | (({1'b0, x_q[i]} + {1'b0, SIZE}) >= {1'b0, X_MAX})
                    | (x_q[i] <= X_MIN + SIZE);
            if (state_q[i] == FLYING) begin
                if (hit[i] || at_edge) begin
                    state_d[i] = IDLE;
                end else begin
                    x_d[i] = x_q[i];
                    y_d[i] = y_q[i];
                    unique case (dir_q[i])
                        2'b00: x_d[i] = x_q[i] - STEP;
                        2'b01: x_d[i] = x_q[i] + STEP;
                        2'b10: y_d[i] = y_q[i] + STEP;
                        2'b11: y_d[i] = y_q[i] - STEP;
                    endcase
                end
            end else if (launch && free_idx == 3'(i)) begin
                state_d[i] = FLYING;
                dir_d[i]   = direction;
            end
            cnt_d = cnt_d + 4'(state_d[i] == FLYING);
        end
    end

    always_comb begin
        fire_d = launch;
        if (launch)
            cd_d = COOLDOWN;
        else if (cd_q != 4'd0)
            cd_d = cd_q - 4'd1;
        else
            cd_d = 4'd0;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= ShipX + ShipS;
                y_q[i]     <= ShipY + ShipS;
                dir_q[i]   <= 2'b00;
            end
            cd_q       <= '0;
            key_prev_q <= 1'b0;
            fire_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                dir_q[i]   <= dir_d[i];
            end
            cd_q       <= cd_d;
            key_prev_q <= key_dn;
            fire_q     <= fire_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            BulletX[10*i +: 10] = x_q[i];
            BulletY[10*i +: 10] = y_q[i];
            bullet_on[i]        = (state_q[i] == FLYING);
        end
    end

    assign BulletS      = SIZE;
    assign fire_event   = fire_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: reference model predicts each frame,
// monitor compares DUT outputs one edge later.
module tb_bullet_pool;
    localparam int N = 4;

    logic              Reset;
    logic              frame_clk = 1'b0;
    logic [1:0]        direction;
    logic [7:0]        keycode;
    logic [9:0]        ShipX, ShipY, ShipS;
    logic [N-1:0]      hit;
    logic [10*N-1:0]   BulletX, BulletY;
    logic [9:0]        BulletS;
    logic [N-1:0]      bullet_on;
    logic              fire_event;
    logic [3:0]        active_count;

    bullet_pool #(.NUM_BULLETS(N)) dut (
        .Reset(Reset), .frame_clk(frame_clk), .direction(direction),
        .keycode(keycode), .ShipX(ShipX), .ShipY(ShipY), .ShipS(ShipS),
        .hit(hit), .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
        .bullet_on(bullet_on), .fire_event(fire_event),
        .active_count(active_count)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [N-1:0]    on;
        logic [10*N-1:0] x;
        logic [10*N-1:0] y;
        logic            fire;
        logic [3:0]      cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_on [N];
    int m_x  [N];
    int m_y  [N];
    int m_dir[N];
    int m_cd;
    bit m_prev;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_on[i] = 0; m_dir[i] = 0;
            m_x[i] = (int'(ShipX) + int'(ShipS)) % 1024;
            m_y[i] = (int'(ShipY) + int'(ShipS)) % 1024;
        end
        m_cd = 0; m_prev = 0;
    endtask

    // One frame of the game rules, computed on plain integers.
    task automatic model_step(logic [7:0] key, logic [1:0] dir,
                              logic [N-1:0] h, output exp_t e);
        int  cx, cy, free, cnt;
        bit  pressed, trig, launch, edge_hit;
        cx = (int'(ShipX) + int'(ShipS)) % 1024;
        cy = (int'(ShipY) + int'(ShipS)) % 1024;
        pressed = (key == 8'd88);
`ifdef AUTO_FIRE_EN
        trig = pressed;
`else
        trig = pressed && !m_prev;
`endif
        free = -1;
        for (int i = 0; i < N; i++)
            if (m_on[i] == 0 && free < 0) free = i;
        launch = trig && m_cd == 0 && free >= 0;
        for (int i = 0; i < N; i++) begin
            if (m_on[i] != 0) begin
                edge_hit = (m_y[i] + 4 >= 479) || (m_y[i] <= 5) ||
                           (m_x[i] + 4 >= 639) || (m_x[i] <= 5);
                if (h[i] || edge_hit) begin
                    m_on[i] = 0; m_x[i] = cx; m_y[i] = cy;
                end else begin
                    case (m_dir[i])
                        0: m_x[i] = (m_x[i] + 1024 - 12) % 1024;
                        1: m_x[i] = (m_x[i] + 12) % 1024;
                        2: m_y[i] = (m_y[i] + 12) % 1024;
                        default: m_y[i] = (m_y[i] + 1024 - 12) % 1024;
                    endcase
                end
            end else begin
                m_x[i] = cx; m_y[i] = cy;
            end
        end
        if (launch) begin
            m_on[free] = 1; m_dir[free] = int'(dir);
        end
        m_cd   = launch ? 6 : (m_cd > 0 ? m_cd - 1 : 0);
        m_prev = pressed;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            e.on[i]         = (m_on[i] != 0);
            e.x[10*i +: 10] = 10'(m_x[i]);
            e.y[10*i +: 10] = 10'(m_y[i]);
            cnt += m_on[i];
        end
        e.fire = launch;
        e.cnt  = 4'(cnt);
    endtask

    task automatic apply(logic [7:0] key, logic [1:0] dir, logic [N-1:0] h);
        exp_t e;
        keycode = key; direction = dir; hit = h;
        model_step(key, dir, h, e);
        sbq.push_back(e);
    endtask

    task automatic frame(logic [7:0] key, logic [1:0] dir, logic [N-1:0] h);
        @(negedge frame_clk);
        apply(key, dir, h);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) frame(8'd0, 2'b00, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("bullet_on", 64'(bullet_on), 64'(e.on));
                check("fire_event", 64'(fire_event), 64'(e.fire));
                check("active_count", 64'(active_count), 64'(e.cnt));
                check("BulletX", 64'(BulletX), 64'(e.x));
                check("BulletY", 64'(BulletY), 64'(e.y));
            end
        end
    end

    initial begin : driver
        logic [7:0] k;
        Reset = 1'b1; keycode = 8'd0; direction = 2'b00; hit = '0;
        ShipX = 10'd100; ShipY = 10'd200; ShipS = 10'd8;
        repeat (3) @(posedge frame_clk);
        #2;
        check("rst_bullet_on", 64'(bullet_on), 64'd0);
        check("rst_fire", 64'(fire_event), 64'd0);
        check("rst_count", 64'(active_count), 64'd0);
        check("rst_size", 64'(BulletS), 64'd4);
        for (int i = 0; i < N; i++) begin
            check("rst_x", 64'(BulletX[10*i +: 10]), 64'd108);
            check("rst_y", 64'(BulletY[10*i +: 10]), 64'd208);
        end
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;

        // single shot right, fly to the edge
        frame(8'd88, 2'b01, '0);
        idle(50);

        // three spaced presses, independent directions
        frame(8'd88, 2'b01, '0); idle(8);
        frame(8'd88, 2'b10, '0); idle(8);
        frame(8'd88, 2'b00, '0); idle(60);

        // second press inside cooldown is dropped
        frame(8'd88, 2'b01, '0); idle(2);
        frame(8'd88, 2'b01, '0); idle(60);

        // fill all slots, kill slot 2, relaunch lowest free
        for (int s = 0; s < 4; s++) begin
            frame(8'd88, 2'b01, '0); idle(7);
        end
        frame(8'd0, 2'b00, 4'b0100);
        idle(2);
        frame(8'd88, 2'b11, '0);
        idle(60);

        // hold the fire key
        for (int f = 0; f < 30; f++) frame(8'd88, 2'b01, '0);
        idle(60);

        // randomized play
        for (int f = 0; f < 600; f++) begin
            @(negedge frame_clk);
            if (f % 20 == 0) begin
                ShipX = 10'($urandom_range(20, 600));
                ShipY = 10'($urandom_range(20, 450));
                ShipS = 10'($urandom_range(0, 15));
            end
            case ($urandom_range(0, 3))
                0, 1:    k = 8'd88;
                2:       k = 8'd0;
                default: k = 8'($urandom_range(1, 87));
            endcase
            apply(k, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
        end

        repeat (3) @(negedge frame_clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
